// File: rtl/cal_pkg.sv
// Shared definitions for the BCD calendar counter: field layout, step units
// and small BCD arithmetic helpers.
package cal_pkg;

    localparam logic [3:0] SEP_NIBBLE_DEF = 4'hA;
    localparam logic [3:0] END_NIBBLE_DEF = 4'hF;

    // Bit offsets of each field inside the 56-bit {YYYY,MM,DD,hh,mm,ss} word
    localparam int YEAR_LSB = 40;
    localparam int MON_LSB  = 32;
    localparam int DAY_LSB  = 24;
    localparam int HH_LSB   = 16;
    localparam int MM_LSB   = 8;
    localparam int SS_LSB   = 0;

    typedef enum logic [1:0] {
        STEP_SEC  = 2'd0,
        STEP_MIN  = 2'd1,
        STEP_HOUR = 2'd2,
        STEP_DAY  = 2'd3
    } step_e;

    function automatic logic bcd_valid_digit(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    // Divisibility by 4 straight from the two BCD digits
    function automatic logic bcd2_div4(input logic [7:0] v);
        if (v[4]) begin
            return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        end else begin
            return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
        end
    endfunction

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    // Increment with wrap: at max the field restarts at lo
    function automatic logic [7:0] bcd2_roll(input logic [7:0] v,
                                             input logic [7:0] max,
                                             input logic [7:0] lo);
        if (v == max) begin
            return lo;
        end else begin
            return bcd2_inc(v);
        end
    endfunction

endpackage

// File: rtl/cal_days_in_month.sv
// Days in a month for a BCD month/year pair, Gregorian leap rule on BCD digits.
// Returns 8'h00 for an out-of-range month so callers reject it.
module cal_days_in_month
    import cal_pkg::*;
(
    input  logic [7:0]  month_i,
    input  logic [15:0] year_i,
    output logic [7:0]  dim_o
);

    logic leap_s;

    // A year ending in 00 is a leap year only when the century is divisible by 4
    assign leap_s = (year_i[7:0] != 8'h00) ? bcd2_div4(year_i[7:0])
                                           : bcd2_div4(year_i[15:8]);

    // Month-length lookup
    always_comb begin
        dim_o = 8'h00;
        case (month_i)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: dim_o = 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                      dim_o = 8'h30;
            8'h02:   dim_o = leap_s ? 8'h29 : 8'h28;
            default: dim_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/bcd_calendar_counter.sv
// BCD date/time counter YYYY-MM-DD hh:mm:ss with selectable step unit,
// validated preset load and packed nibble stream for the display chain.
module bcd_calendar_counter
    import cal_pkg::*;
#(
    parameter logic [15:0] INIT_YEAR  = 16'h2025,
    parameter logic [7:0]  INIT_MONTH = 8'h05,
    parameter logic [7:0]  INIT_DAY   = 8'h01,
    parameter logic [23:0] INIT_TIME  = 24'h000000,
    parameter logic [3:0]  SEP_NIBBLE = SEP_NIBBLE_DEF,
    parameter logic [3:0]  END_NIBBLE = END_NIBBLE_DEF
) (
    input  logic        clock_clk,
    input  logic        reset,
    input  logic        tick_en_i,
    input  logic [1:0]  step_sel_i,
    input  logic        load_en_i,
    input  logic [55:0] load_bcd_i,
    output logic [55:0] bcd_out_o,
    output logic [83:0] packed_out_o,
    output logic        day_wrap_o,
    output logic        year_wrap_o,
    output logic        load_err_o
);

    localparam logic [55:0] INIT_BANK = {INIT_YEAR, INIT_MONTH, INIT_DAY, INIT_TIME};

    logic [55:0] bank_q, bank_d, inc_bank_s;
    logic        day_wrap_q, day_wrap_d;
    logic        year_wrap_q, year_wrap_d;
    logic        load_err_q, load_err_d;

    logic [15:0] year_s;
    logic [7:0]  mon_s, day_s, hh_s, mm_s, ss_s, dim_cur_s, dim_ld_s;
    step_e       step_s;
    logic        inc_ss_s, inc_mm_s, inc_hh_s, inc_day_s, inc_mon_s, inc_yr_s, inc_yhi_s;
    logic        digits_ok_s, load_ok_s;

    assign year_s = bank_q[YEAR_LSB +: 16];
    assign mon_s  = bank_q[MON_LSB +: 8];
    assign day_s  = bank_q[DAY_LSB +: 8];
    assign hh_s   = bank_q[HH_LSB +: 8];
    assign mm_s   = bank_q[MM_LSB +: 8];
    assign ss_s   = bank_q[SS_LSB +: 8];
    assign step_s = step_e'(step_sel_i);

    cal_days_in_month u_dim_cur (
        .month_i (mon_s),
        .year_i  (year_s),
        .dim_o   (dim_cur_s)
    );

    cal_days_in_month u_dim_ld (
        .month_i (load_bcd_i[MON_LSB +: 8]),
        .year_i  (load_bcd_i[YEAR_LSB +: 16]),
        .dim_o   (dim_ld_s)
    );

    // Carry chain: each field advances when the step enters there or the field below wraps
    assign inc_ss_s  = tick_en_i && (step_s == STEP_SEC);
    assign inc_mm_s  = (inc_ss_s && (ss_s == 8'h59)) || (tick_en_i && (step_s == STEP_MIN));
    assign inc_hh_s  = (inc_mm_s && (mm_s == 8'h59)) || (tick_en_i && (step_s == STEP_HOUR));
    assign inc_day_s = (inc_hh_s && (hh_s == 8'h23)) || (tick_en_i && (step_s == STEP_DAY));
    assign inc_mon_s = inc_day_s && (day_s == dim_cur_s);
    assign inc_yr_s  = inc_mon_s && (mon_s == 8'h12);
    assign inc_yhi_s = inc_yr_s && (year_s[7:0] == 8'h99);

    assign inc_bank_s = {
        inc_yhi_s ? bcd2_roll(year_s[15:8], 8'h99, 8'h00) : year_s[15:8],
        inc_yr_s  ? bcd2_roll(year_s[7:0],  8'h99, 8'h00) : year_s[7:0],
        inc_mon_s ? bcd2_roll(mon_s, 8'h12, 8'h01)        : mon_s,
        inc_day_s ? bcd2_roll(day_s, dim_cur_s, 8'h01)    : day_s,
        inc_hh_s  ? bcd2_roll(hh_s, 8'h23, 8'h00)         : hh_s,
        inc_mm_s  ? bcd2_roll(mm_s, 8'h59, 8'h00)         : mm_s,
        inc_ss_s  ? bcd2_roll(ss_s, 8'h59, 8'h00)         : ss_s
    };

    // Preset validation; byte compares are meaningful once every digit is 0..9
    always_comb begin
        digits_ok_s = 1'b1;
        for (int i = 0; i < 14; i++) begin
            digits_ok_s = digits_ok_s & bcd_valid_digit(load_bcd_i[4*i +: 4]);
        end
        load_ok_s = digits_ok_s
                 && (load_bcd_i[MON_LSB +: 8] >= 8'h01) && (load_bcd_i[MON_LSB +: 8] <= 8'h12)
                 && (load_bcd_i[DAY_LSB +: 8] >= 8'h01) && (load_bcd_i[DAY_LSB +: 8] <= dim_ld_s)
                 && (load_bcd_i[HH_LSB +: 8] <= 8'h23)
                 && (load_bcd_i[MM_LSB +: 8] <= 8'h59)
                 && (load_bcd_i[SS_LSB +: 8] <= 8'h59);
    end

    // Next state: a load strobe takes priority and swallows any tick in the same cycle
    always_comb begin
        bank_d      = bank_q;
        day_wrap_d  = 1'b0;
        year_wrap_d = 1'b0;
        load_err_d  = 1'b0;
        if (load_en_i) begin
            if (load_ok_s) begin
                bank_d = load_bcd_i;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            bank_d      = inc_bank_s;
            day_wrap_d  = inc_day_s;
            year_wrap_d = inc_yr_s;
        end
    end

    // Digit bank and pulse registers
    always_ff @(posedge clock_clk or negedge reset) begin
        if (!reset) begin
            bank_q      <= INIT_BANK;
            day_wrap_q  <= 1'b0;
            year_wrap_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            day_wrap_q  <= day_wrap_d;
            year_wrap_q <= year_wrap_d;
            load_err_q  <= load_err_d;
        end
    end

    assign bcd_out_o    = bank_q;
    assign day_wrap_o   = day_wrap_q;
    assign year_wrap_o  = year_wrap_q;
    assign load_err_o   = load_err_q;
    assign packed_out_o = {year_s, SEP_NIBBLE, mon_s, SEP_NIBBLE, day_s, SEP_NIBBLE,
                           hh_s, SEP_NIBBLE, mm_s, SEP_NIBBLE, ss_s, SEP_NIBBLE, END_NIBBLE};

endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Self-checking bench for bcd_calendar_counter: vector table replayed through
// a scoreboard queue, plus hand sequences for year wrap and mid-run reset.
module tb_bcd_calendar_counter;

    logic        clock_clk = 1'b0;
    logic        reset;
    logic        tick_en_i;
    logic [1:0]  step_sel_i;
    logic        load_en_i;
    logic [55:0] load_bcd_i;
    logic [55:0] bcd_out_o;
    logic [83:0] packed_out_o;
    logic        day_wrap_o;
    logic        year_wrap_o;
    logic        load_err_o;

    localparam logic [55:0] INIT_VAL = 56'h20250501000000;

    typedef struct {
        logic        ld;
        logic [55:0] val;
        logic        tk;
        logic [1:0]  st;
        logic [55:0] exp;
        logic        dw;
        logic        yw;
        logic        er;
    } vec_t;

    typedef struct {
        logic [55:0] bcd;
        logic        dw;
        logic        yw;
        logic        er;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    bcd_calendar_counter dut (
        .clock_clk    (clock_clk),
        .reset        (reset),
        .tick_en_i    (tick_en_i),
        .step_sel_i   (step_sel_i),
        .load_en_i    (load_en_i),
        .load_bcd_i   (load_bcd_i),
        .bcd_out_o    (bcd_out_o),
        .packed_out_o (packed_out_o),
        .day_wrap_o   (day_wrap_o),
        .year_wrap_o  (year_wrap_o),
        .load_err_o   (load_err_o)
    );

    always #5 clock_clk = ~clock_clk;

    function automatic logic [83:0] pack_model(input logic [55:0] b);
        return {b[55:40], 4'hA, b[39:32], 4'hA, b[31:24], 4'hA,
                b[23:16], 4'hA, b[15:8], 4'hA, b[7:0], 4'hA, 4'hF};
    endfunction

    task automatic check(input string name, input logic [83:0] act, input logic [83:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic ld, input logic [55:0] val, input logic tk,
                           input logic [1:0] st, input logic [55:0] exp,
                           input logic dw, input logic yw, input logic er);
        vec_t v;
        v.ld = ld; v.val = val; v.tk = tk; v.st = st;
        v.exp = exp; v.dw = dw; v.yw = yw; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic [55:0] bcd,
                                 input logic dw, input logic yw, input logic er);
        check({tag, ".bcd"}, {28'h0, bcd_out_o}, {28'h0, bcd});
        check({tag, ".packed"}, packed_out_o, pack_model(bcd));
        check({tag, ".day_wrap"}, {83'h0, day_wrap_o}, {83'h0, dw});
        check({tag, ".year_wrap"}, {83'h0, year_wrap_o}, {83'h0, yw});
        check({tag, ".load_err"}, {83'h0, load_err_o}, {83'h0, er});
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic run_cycle(input string tag, input vec_t v);
        exp_t e;
        @(negedge clock_clk);
        load_en_i  = v.ld;
        load_bcd_i = v.val;
        tick_en_i  = v.tk;
        step_sel_i = v.st;
        e.bcd = v.exp; e.dw = v.dw; e.yw = v.yw; e.er = v.er;
        sb.push_back(e);
        @(posedge clock_clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s.scoreboard: got empty queue, expected one entry", tag);
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e.bcd, e.dw, e.yw, e.er);
        end
    endtask

    initial begin
        vec_t hv;
        reset      = 1'b0;
        tick_en_i  = 1'b0;
        step_sel_i = 2'd0;
        load_en_i  = 1'b0;
        load_bcd_i = 56'h0;

        //       ld    load value            tk    st     expected bcd          dw    yw    er
        add_vec(1'b0, 56'h0,               1'b0, 2'd0, 56'h20250501000000, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 56'h20240228235959,  1'b0, 2'd0, 56'h20240228235959, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 56'h0,               1'b1, 2'd0, 56'h20240229000000, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 56'h0,               1'b0, 2'd0, 56'h20240229000000, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 56'h21000228235959,  1'b0, 2'd0, 56'h21000228235959, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 56'h0,               1'b1, 2'd0, 56'h21000301000000, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 56'h20000228235959,  1'b0, 2'd0, 56'h20000228235959, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 56'h0,               1'b1, 2'd0, 56'h20000229000000, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 56'h99991231235959,  1'b0, 2'd0, 56'h99991231235959, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 56'h0,               1'b1, 2'd0, 56'h00000101000000, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 56'h0,               1'b0, 2'd0, 56'h00000101000000, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 56'h20250431120000,  1'b0, 2'd0, 56'h00000101000000, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 56'h20250131102030,  1'b1, 2'd0, 56'h20250131102030, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 56'h0,               1'b1, 2'd3, 56'h20250201102030, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 56'h20250201234512,  1'b0, 2'd0, 56'h20250201234512, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 56'h0,               1'b1, 2'd2, 56'h20250202004512, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 56'h0,               1'b1, 2'd1, 56'h20250202004612, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 56'h20230229000000,  1'b0, 2'd0, 56'h20250202004612, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 56'h20251301000000,  1'b0, 2'd0, 56'h20250202004612, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 56'h202505A1000000,  1'b0, 2'd0, 56'h20250202004612, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 56'h20250501240000,  1'b0, 2'd0, 56'h20250202004612, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 56'h20250501005960,  1'b0, 2'd0, 56'h20250202004612, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 56'h20250500000000,  1'b0, 2'd0, 56'h20250202004612, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 56'h20241231120000,  1'b0, 2'd0, 56'h20241231120000, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 56'h0,               1'b1, 2'd3, 56'h20250101120000, 1'b1, 1'b1, 1'b0);
        add_vec(1'b1, 56'h20240229235959,  1'b0, 2'd0, 56'h20240229235959, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 56'h0,               1'b1, 2'd2, 56'h20240301005959, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 56'h20250230000000,  1'b1, 2'd0, 56'h20240301005959, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 56'h0,               1'b1, 2'd0, 56'h20240301010000, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 56'h20250930235959,  1'b0, 2'd0, 56'h20250930235959, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 56'h0,               1'b1, 2'd0, 56'h20251001000000, 1'b1, 1'b0, 1'b0);

        repeat (2) @(posedge clock_clk);
        #1;
        check_outputs("reset", INIT_VAL, 1'b0, 1'b0, 1'b0);
        @(negedge clock_clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_cycle($sformatf("vec%0d", i), vecs[i]);
        end

        // Year wrap pulse lasts exactly one cycle
        hv.ld = 1'b1; hv.val = 56'h20251231235959; hv.tk = 1'b0; hv.st = 2'd0;
        hv.exp = 56'h20251231235959; hv.dw = 1'b0; hv.yw = 1'b0; hv.er = 1'b0;
        run_cycle("seq_load", hv);
        hv.ld = 1'b0; hv.val = 56'h0; hv.tk = 1'b1; hv.st = 2'd0;
        hv.exp = 56'h20260101000000; hv.dw = 1'b1; hv.yw = 1'b1;
        run_cycle("seq_ywrap", hv);

        // Asynchronous reset between edges while pulses are high
        #2;
        reset = 1'b0;
        #1;
        check_outputs("mid_reset", INIT_VAL, 1'b0, 1'b0, 1'b0);
        @(negedge clock_clk);
        tick_en_i = 1'b0;
        @(posedge clock_clk);
        #1;
        check_outputs("held_reset", INIT_VAL, 1'b0, 1'b0, 1'b0);
        @(negedge clock_clk);
        reset = 1'b1;
        hv.ld = 1'b0; hv.val = 56'h0; hv.tk = 1'b1; hv.st = 2'd1;
        hv.exp = 56'h20250501000100; hv.dw = 1'b0; hv.yw = 1'b0; hv.er = 1'b0;
        run_cycle("post_reset_min", hv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
